// File: rtl/sm_hex_scan.sv
// Time-multiplexed hex display driver for a DIGITS-wide 7-segment board display.
// The data word is shadowed once per scan frame so mid-frame updates never tear.
module sm_hex_scan #(
  parameter int DIGITS         = 8,
  parameter int PRESCALE       = 16,
  parameter int GUARD          = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dpIn,
  input  logic                  blankLz,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRESCALE-1:0] CNT_MAX   = '1;
  localparam logic [PRESCALE-1:0] GUARD_END = PRESCALE'(GUARD);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(DIGITS - 1);
  localparam logic                SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic                AN_INV    = (AN_ACTIVE_LOW != 0);

  logic [PRESCALE-1:0] cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;

  logic                tick;
  logic                last;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                lz_sel;
  logic                zero_run;
  logic                blank;
  logic [DIGITS-1:0]   lead_zero;
  logic [DIGITS-1:0]   an_sel;
  logic [DIGITS-1:0]   an_lit;
  logic [6:0]          seg_lit;
  logic                dp_lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick = (cnt == CNT_MAX);
  assign last = (idx == IDX_LAST);

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    zero_run  = 1'b1;
    lead_zero = '0;
    an_sel    = '0;
    // lead_zero[i]: nibbles i..DIGITS-1 are all zero; digit 0 is never blanked
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (sh_data[4*(DIGITS-1-i) +: 4] == 4'h0);
      lead_zero[DIGITS-1-i] = zero_run;
    end
    lead_zero[0] = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = sh_data[4*i +: 4];
        dp_sel    = sh_dp[i];
        lz_sel    = lead_zero[i];
        an_sel[i] = 1'b1;
      end
    end
    blank   = blankLz & lz_sel;
    seg_lit = blank ? 7'h00 : hex7(nib);
    dp_lit  = ~blank & dp_sel;
    an_lit  = (cnt < GUARD_END) ? '0 : an_sel;
  end

  // Outputs are built from pre-edge cnt/idx/shadow, so they lag the scan state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      sh_data  <= '0;
      sh_dp    <= '0;
      anodes   <= {DIGITS{AN_INV}};
      segments <= {7{SEG_INV}};
      dp       <= SEG_INV;
      frame    <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          sh_data <= data;
          sh_dp   <= dpIn;
        end
      end
      frame    <= tick & last;
      anodes   <= an_lit ^ {DIGITS{AN_INV}};
      segments <= seg_lit ^ {7{SEG_INV}};
      dp       <= dp_lit ^ SEG_INV;
    end
  end

endmodule
